// File: rtl/traffic_light_sequencer.sv
// Turns the software command byte into safely timed lamp outputs for two approaches.
// Minimum green, amber, all-red clearance and flash cadence are enforced here, not in software.
module traffic_light_sequencer #(
  parameter int MIN_GREEN_CYCLES = 8,
  parameter int AMBER_CYCLES     = 4,
  parameter int ALLRED_CYCLES    = 3,
  parameter int FLASH_CYCLES     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cmd,
  output logic [2:0] ns_lights,
  output logic [2:0] ew_lights,
  output logic [2:0] phase,
  output logic       cmd_err
);

  typedef enum logic [2:0] {
    ALL_RED  = 3'd0,
    NS_GREEN = 3'd1,
    NS_AMBER = 3'd2,
    EW_GREEN = 3'd3,
    EW_AMBER = 3'd4,
    FLASH    = 3'd5
  } state_t;

  localparam logic [31:0] GREEN_LOAD  = 32'(MIN_GREEN_CYCLES - 1);
  localparam logic [31:0] AMBER_LOAD  = 32'(AMBER_CYCLES - 1);
  localparam logic [31:0] ALLRED_LOAD = 32'(ALLRED_CYCLES - 1);
  localparam logic [31:0] FLASH_LOAD  = 32'(FLASH_CYCLES - 1);

  localparam logic [2:0] LAMP_RED   = 3'b100;
  localparam logic [2:0] LAMP_AMBER = 3'b010;
  localparam logic [2:0] LAMP_GREEN = 3'b001;

  state_t      state, next_state;
  logic [31:0] timer, next_timer;
  logic        flash_phase, next_flash_phase;
  logic [2:0]  next_ns, next_ew;

  logic [1:0] req;
  logic       flash;
  logic       expired;
  logic       unused_cmd_bits;

  assign req             = cmd[1:0];
  assign flash           = cmd[2];
  assign expired         = (timer == 32'd0);
  assign unused_cmd_bits = ^cmd[7:3];

  // Decisions are taken only on timer expiry, except leaving FLASH which is immediate.
  always_comb begin
    next_state       = state;
    next_timer       = expired ? 32'd0 : timer - 32'd1;
    next_flash_phase = flash_phase;
    case (state)
      ALL_RED: begin
        if (expired) begin
          if (flash) begin
            next_state       = FLASH;
            next_timer       = FLASH_LOAD;
            next_flash_phase = 1'b1;
          end else if (req == 2'd1) begin
            next_state = NS_GREEN;
            next_timer = GREEN_LOAD;
          end else if (req == 2'd2) begin
            next_state = EW_GREEN;
            next_timer = GREEN_LOAD;
          end
        end
      end
      NS_GREEN: begin
        if (expired && (req != 2'd1 || flash)) begin
          next_state = NS_AMBER;
          next_timer = AMBER_LOAD;
        end
      end
      EW_GREEN: begin
        if (expired && (req != 2'd2 || flash)) begin
          next_state = EW_AMBER;
          next_timer = AMBER_LOAD;
        end
      end
      NS_AMBER, EW_AMBER: begin
        if (expired) begin
          next_state = ALL_RED;
          next_timer = ALLRED_LOAD;
        end
      end
      FLASH: begin
        if (!flash) begin
          next_state       = ALL_RED;
          next_timer       = ALLRED_LOAD;
          next_flash_phase = 1'b0;
        end else if (expired) begin
          next_timer       = FLASH_LOAD;
          next_flash_phase = ~flash_phase;
        end
      end
      default: begin
        next_state = ALL_RED;
        next_timer = ALLRED_LOAD;
      end
    endcase
  end

  always_comb begin
    next_ns = LAMP_RED;
    next_ew = LAMP_RED;
    case (next_state)
      NS_GREEN: next_ns = LAMP_GREEN;
      NS_AMBER: next_ns = LAMP_AMBER;
      EW_GREEN: next_ew = LAMP_GREEN;
      EW_AMBER: next_ew = LAMP_AMBER;
      FLASH: begin
        next_ns = {1'b0, next_flash_phase, 1'b0};
        next_ew = {1'b0, next_flash_phase, 1'b0};
      end
      default: begin
        next_ns = LAMP_RED;
        next_ew = LAMP_RED;
      end
    endcase
  end

  // Lamps are registered alongside the state so cmd never reaches them combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ALL_RED;
      timer       <= ALLRED_LOAD;
      flash_phase <= 1'b0;
      ns_lights   <= LAMP_RED;
      ew_lights   <= LAMP_RED;
      phase       <= 3'd0;
      cmd_err     <= 1'b0;
    end else begin
      state       <= next_state;
      timer       <= next_timer;
      flash_phase <= next_flash_phase;
      ns_lights   <= next_ns;
      ew_lights   <= next_ew;
      phase       <= next_state;
      cmd_err     <= (req == 2'd3);
    end
  end

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Directed bench for traffic_light_sequencer: expected lamp/phase/error values are queued
// with each stimulus step and compared one edge later.
module tb_traffic_light_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] cmd;
  logic [2:0] ns_lights;
  logic [2:0] ew_lights;
  logic [2:0] phase;
  logic       cmd_err;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] A = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] D = 3'b000;

  traffic_light_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd       (cmd),
    .ns_lights (ns_lights),
    .ew_lights (ew_lights),
    .phase     (phase),
    .cmd_err   (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [7:0] c, input logic [2:0] ns, input logic [2:0] ew,
                               input logic [2:0] ph, input logic err, input string tag);
    exp_t e;
    cmd   = c;
    e.tag = tag;
    e.exp = {ns, ew, ph, err};
    sbq.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [9:0] obs;
    obs = {ns_lights, ew_lights, phase, cmd_err};
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_empty got=%b required=queued_entry", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.exp) else begin
        bad++;
        $error("[TB] FAIL %s got ns=%b ew=%b ph=%0d err=%b required ns=%b ew=%b ph=%0d err=%b",
               e.tag, obs[9:7], obs[6:4], obs[3:1], obs[0],
               e.exp[9:7], e.exp[6:4], e.exp[3:1], e.exp[0]);
      end
    end
  endtask

  // One clock step: drive cmd, expect the given outputs right after the next edge.
  task automatic step(input logic [7:0] c, input logic [2:0] ns, input logic [2:0] ew,
                      input logic [2:0] ph, input logic err, input string tag);
    applyStimulus(c, ns, ew, ph, err, tag);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Reset is asserted between edges and checked before any clock arrives.
  task automatic doReset(input logic [7:0] c);
    reset = 1'b1;
    applyStimulus(c, R, R, 3'd0, 1'b0, "async_reset");
    #1;
    checkOutput();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cmd   = 8'h00;
    #12;

    // Power-up to NS green, then hand over to EW.
    doReset(8'h01);
    step(8'h01, R, R, 3'd0, 1'b0, "pwr_red_e1");
    step(8'h01, R, R, 3'd0, 1'b0, "pwr_red_e2");
    step(8'h01, G, R, 3'd1, 1'b0, "ns_green_e3");
    for (int i = 4; i <= 10; i++) step(8'h02, G, R, 3'd1, 1'b0, "ns_min_green");
    for (int i = 11; i <= 14; i++) step(8'h02, A, R, 3'd2, 1'b0, "ns_amber");
    for (int i = 15; i <= 17; i++) step(8'h02, R, R, 3'd0, 1'b0, "clear_red");
    step(8'h02, R, G, 3'd3, 1'b0, "ew_green_e18");
    for (int i = 19; i <= 28; i++) step(8'h02, R, G, 3'd3, 1'b0, "ew_green_hold");

    // Flash request from EW green: amber, all-red, then flashing cadence.
    for (int i = 0; i < 4; i++) step(8'h06, R, A, 3'd4, 1'b0, "ew_amber");
    for (int i = 0; i < 3; i++) step(8'h06, R, R, 3'd0, 1'b0, "pre_flash_red");
    for (int i = 0; i < 5; i++) step(8'h06, A, A, 3'd5, 1'b0, "flash_on");
    for (int i = 0; i < 5; i++) step(8'h06, D, D, 3'd5, 1'b0, "flash_off");
    for (int i = 0; i < 2; i++) step(8'h06, A, A, 3'd5, 1'b0, "flash_on2");
    step(8'h02, R, R, 3'd0, 1'b0, "flash_exit");
    step(8'h02, R, R, 3'd0, 1'b0, "post_flash_red");
    step(8'h02, R, R, 3'd0, 1'b0, "post_flash_red");
    step(8'h02, R, G, 3'd3, 1'b0, "ew_after_flash");

    // Invalid request: error flag, lamps stay red, recovery on valid request.
    doReset(8'h03);
    step(8'h03, R, R, 3'd0, 1'b1, "err_e1");
    step(8'h03, R, R, 3'd0, 1'b1, "err_e2");
    step(8'h01, G, R, 3'd1, 1'b0, "err_clear_green");

    // All-red with no request holds indefinitely.
    doReset(8'h00);
    for (int i = 0; i < 6; i++) step(8'h00, R, R, 3'd0, 1'b0, "idle_red");
    step(8'h01, G, R, 3'd1, 1'b0, "late_ns_green");

    // Reset asserted mid-amber.
    doReset(8'h01);
    step(8'h01, R, R, 3'd0, 1'b0, "r2_red_e1");
    step(8'h01, R, R, 3'd0, 1'b0, "r2_red_e2");
    for (int i = 3; i <= 11; i++) step(8'h01, G, R, 3'd1, 1'b0, "r2_ns_green");
    step(8'h00, A, R, 3'd2, 1'b0, "r2_amber1");
    step(8'h00, A, R, 3'd2, 1'b0, "r2_amber2");
    doReset(8'h01);
    step(8'h01, R, R, 3'd0, 1'b0, "r3_red_e1");
    step(8'h01, R, R, 3'd0, 1'b0, "r3_red_e2");
    step(8'h01, G, R, 3'd1, 1'b0, "r3_green_e3");

    // Upper command bits are ignored.
    doReset(8'hF9);
    step(8'hF9, R, R, 3'd0, 1'b0, "hi_red_e1");
    step(8'hF9, R, R, 3'd0, 1'b0, "hi_red_e2");
    step(8'hF9, G, R, 3'd1, 1'b0, "hi_green_e3");
    step(8'hFB, G, R, 3'd1, 1'b1, "hi_err_flag");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_light_sequencer.md
# traffic_light_sequencer

Consumes the 8-bit command byte driven by the HPS-writable PIO output port and turns it into safe, timed light outputs for the two intersection approaches (north-south, east-west). Software only requests which approach gets green, or flashing mode. This block enforces the safety timing in hardware: minimum green, amber, all-red clearance and flash cadence. Software therefore cannot produce conflicting greens or skip an amber/all-red interval.

## Interface
- MIN_GREEN_CYCLES, default 8: minimum number of cycles a green is held; must be ≥1.
- AMBER_CYCLES, default 4: duration of each amber interval; must be ≥1.
- ALLRED_CYCLES, default 3: duration of the all-red clearance; must be ≥1.
- FLASH_CYCLES, default 5: half-period of amber flashing; must be ≥1.
- clk  in  1  system clock, shared with the PIO.
- reset  in  1  asynchronous, active-high reset.
- cmd  in  8  PIO output byte in the same clock domain, no synchroniser. Bits [1:0] req: 0 = all red, 1 = NS green, 2 = EW green, 3 = invalid. Bit [2] = flash. Bits [7:3] are ignored.
- ns_lights  out  3  NS lamps {red, amber, green}.
- ew_lights  out  3  EW lamps {red, amber, green}.
- phase  out  3  current state code: ALL_RED=0, NS_GREEN=1, NS_AMBER=2, EW_GREEN=3, EW_AMBER=4, FLASH=5.
- cmd_err  out  1  registered; high on the cycle after a cycle where req==3.

## Operation
- State register: one of six states. The 32-bit down-counter `timer` is loaded with N-1 on entry to a timed state and decrements each cycle while nonzero. The timer is "expired" when timer==0, so every timed state lasts at least N cycles.
- ALL_RED: both outputs 3'b100. When expired, exit as follows, with flash taking priority:
  - flash=1 → FLASH.
  - req=1 → NS_GREEN.
  - req=2 → EW_GREEN.
  - req=0 or 3 → stay in ALL_RED, timer held at 0.
- NS_GREEN: ns=3'b001, ew=3'b100, timer loads MIN_GREEN_CYCLES-1. When expired and (req≠1 or flash=1) → NS_AMBER. Otherwise hold green indefinitely.
- NS_AMBER: ns=3'b010, ew=3'b100, timer loads AMBER_CYCLES-1. When expired → ALL_RED.
- EW_GREEN and EW_AMBER mirror NS_GREEN and NS_AMBER, with the roles of req=2 and req=1 swapped.
- A green is never followed by anything except its own amber. Amber is always followed by ALL_RED, which reloads ALLRED_CYCLES-1. The two approaches are never green or amber at the same time.
- FLASH:
  - Both outputs are {0, flash_phase, 0}.
  - On entry, flash_phase=1 and timer=FLASH_CYCLES-1.
  - On expiry, flash_phase toggles and the timer reloads.
  - When flash=0 is sampled → ALL_RED on the next edge, regardless of timer.
- Reaching FLASH from a green always passes through amber and then ALL_RED.
- req==3 is treated as req==0, and cmd_err asserts. cmd_err is not sticky.
- cmd changes mid-interval have no effect until the current timer expires. The exception is that dropping flash in FLASH takes effect immediately.

## Timing
- All outputs are decoded from registered state and flash_phase: no combinational path from cmd to the lamps.
- Decisions are made on the edge where timer==0. The new state and lamps are visible right after that edge.
- Reset, asynchronously and at any time including mid-amber:
  - state=ALL_RED, timer=ALLRED_CYCLES-1.
  - ns_lights=ew_lights=3'b100, phase=0, cmd_err=0, flash_phase=0.
- Edge numbering: edge 1 is the first rising clk edge after reset deasserts.
- The minimum latency from reset release to a green is ALLRED_CYCLES edges.
- Timers are 32 bits wide and never wrap: they decrement only while nonzero.

## Test plan
Default parameters throughout.
- Reset, then cmd=0x01 held: ALL_RED through edge 2. Edge 3 → ns=001, ew=100, phase=1.
- From the previous scenario, cmd=0x02 at edge 4:
  - NS green held through edge 10.
  - Edge 11 → ns=010 for 4 cycles.
  - Edge 15 → both 100.
  - Edge 18 → ew=001, phase=3.
  - No cycle has both approaches non-red.
- In EW_GREEN past the minimum green, cmd=0x06: EW_AMBER for 4 cycles, then ALL_RED for 3, then FLASH. Both outputs are 010 for 5 cycles, then 000 for 5, then repeat. Setting cmd=0x02 exits to ALL_RED on the next edge.
- cmd=0x03 after reset: cmd_err=1 from edge 1 onward and lamps stay 100/100. cmd=0x01 then gives cmd_err=0 next cycle and NS green at edge 3 (ALL_RED expiry).
- Assert reset 2 cycles into NS_AMBER: lamps go to 100/100 immediately without waiting for a clock. After release with cmd=0x01, green returns at edge 3.
- cmd=0xF9 behaves exactly as cmd=0x01, since bits [7:3] are ignored.
